// File: rtl/nlms_pkg.sv
// Shared types for the NLMS output-buffer read path.
package nlms_pkg;

  // Read-manager control states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } out_rd_state_t;

  // Prefetch FIFO depth; the read-issue rule is built around this value.
  localparam int OUT_RD_FIFO_DEPTH = 2;

endpackage

// File: rtl/nlms_out_buff_read_manager_if.sv
// Out-buffer read port plus the AXI4-Stream output, bundled for the read manager.
interface nlms_out_buff_read_manager_if #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int ADDR_WIDTH   = 10
);
  logic                    out_buff_re;
  logic [ADDR_WIDTH-1:0]   out_buff_raddr;
  logic [SAMPLE_WIDTH-1:0] out_buff_rdata;
  logic [SAMPLE_WIDTH-1:0] m_axis_tdata;
  logic                    m_axis_tvalid;
  logic                    m_axis_tready;
  logic                    m_axis_tlast;

  // Read manager side: drives the buffer read port and the stream.
  modport master (
    output out_buff_re, out_buff_raddr, m_axis_tdata, m_axis_tvalid, m_axis_tlast,
    input  out_buff_rdata, m_axis_tready
  );

  // Buffer / downstream side.
  modport slave (
    input  out_buff_re, out_buff_raddr, m_axis_tdata, m_axis_tvalid, m_axis_tlast,
    output out_buff_rdata, m_axis_tready
  );
endinterface

// File: rtl/nlms_skid_fifo.sv
// 2-entry FIFO with a registered head; push and pop may coincide.
// The caller guarantees no push when full and no pop when empty.
module nlms_skid_fifo #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             valid,
  output logic [1:0]       count
);

  logic [1:0][WIDTH-1:0] mem;
  logic                  wr_ptr;
  logic                  rd_ptr;

  // Storage, pointers and occupancy; reset clears everything so head reads 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem    <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Head only moves on pop: a push lands in the other slot when non-empty.
  assign head  = mem[rd_ptr];
  assign valid = (count != 2'd0);

endmodule

// File: rtl/nlms_out_buff_read_manager.sv
// Streams a block of samples from the out buffer onto AXI4-Stream,
// prefetching through the buffer's 1-cycle read latency into a 2-entry FIFO.
module nlms_out_buff_read_manager
  import nlms_pkg::*;
#(
  parameter  int SAMPLE_WIDTH         = 16,
  parameter  int LOG2_X_D_BUFF_HEIGHT = 10,
  localparam int OUT_BUFF_ADDR_WIDTH  = LOG2_X_D_BUFF_HEIGHT
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         start,
  input  logic [OUT_BUFF_ADDR_WIDTH:0] sample_count,
  output logic                         busy,
  output logic                         done,
  nlms_out_buff_read_manager_if.master bus
);

  localparam int AW = OUT_BUFF_ADDR_WIDTH;
  localparam logic [AW:0] CNT_ONE = (AW+1)'(1);

  out_rd_state_t           state;
  logic [AW:0]             rem_reads;
  logic [AW:0]             rem_beats;
  logic [AW-1:0]           raddr;
  logic                    inflight;
  logic                    zero_done;

  logic [1:0]              fifo_count;
  logic                    fifo_valid;
  logic [SAMPLE_WIDTH-1:0] fifo_head;
  logic                    push;
  logic                    pop;
  logic [2:0]              occ;
  logic                    re;
  logic                    last_hs;

  // A handshake only counts while enabled; a returning read is pushed the
  // cycle after it was issued.
  assign pop     = en && fifo_valid && bus.m_axis_tready;
  assign push    = en && inflight;
  assign last_hs = pop && (rem_beats == CNT_ONE);

  // Projected occupancy after this cycle's pop, counting the read in flight.
  // Keeping it below 2 is what makes FIFO overflow impossible.
  assign occ = {1'b0, fifo_count} + {2'b0, inflight} - {2'b0, pop};
  assign re  = en && (state == STREAM) && (rem_reads != '0) && (occ < 3'd2);

  nlms_skid_fifo #(.WIDTH(SAMPLE_WIDTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (bus.out_buff_rdata),
    .head  (fifo_head),
    .valid (fifo_valid),
    .count (fifo_count)
  );

  // Control FSM with its counters, read address and in-flight tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rem_reads <= '0;
      rem_beats <= '0;
      raddr     <= '0;
      inflight  <= 1'b0;
      zero_done <= 1'b0;
    end else if (en) begin
      inflight  <= re;
      zero_done <= 1'b0;
      if (re) begin
        rem_reads <= rem_reads - CNT_ONE;
        raddr     <= raddr + AW'(1);
      end
      if (pop) rem_beats <= rem_beats - CNT_ONE;
      case (state)
        IDLE: begin
          if (start) begin
            if (sample_count != '0) begin
              state     <= STREAM;
              rem_reads <= sample_count;
              rem_beats <= sample_count;
              raddr     <= '0;
            end else begin
              // Empty block: nothing to move, just acknowledge next cycle.
              zero_done <= 1'b1;
            end
          end
        end
        STREAM: begin
          if (last_hs)                           state <= IDLE;
          else if (re && rem_reads == CNT_ONE)   state <= DRAIN;
        end
        DRAIN: begin
          if (last_hs) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Done coincides with the final handshake so an N-sample block
  // completes in cycle N+2 after start.
  assign busy = (state != IDLE);
  assign done = zero_done || last_hs;

  assign bus.out_buff_re    = re;
  assign bus.out_buff_raddr = raddr;
  assign bus.m_axis_tdata   = fifo_head;
  assign bus.m_axis_tvalid  = fifo_valid;
  assign bus.m_axis_tlast   = fifo_valid && (rem_beats == CNT_ONE);

endmodule

// File: tb/tb_nlms_out_buff_read_manager.sv
// Directed bench for nlms_out_buff_read_manager: a per-cycle vector table for
// reset, empty block and a 4-sample block, then stream sequences for
// backpressure, full depth, mid-stream reset and enable gaps.
module tb_nlms_out_buff_read_manager;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        start;
  logic [10:0] sample_count;
  logic        busy;
  logic        done;

  logic [15:0] mem [0:1023];
  int          n_vec = 0;
  int          n_err = 0;
  int          max_cnt = 0;

  nlms_out_buff_read_manager_if #(.SAMPLE_WIDTH(16), .ADDR_WIDTH(10)) bus ();

  nlms_out_buff_read_manager #(.SAMPLE_WIDTH(16), .LOG2_X_D_BUFF_HEIGHT(10)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .start        (start),
    .sample_count (sample_count),
    .busy         (busy),
    .done         (done),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  // Out-buffer model: 1-cycle registered read, stalled by the global enable.
  always @(posedge clk)
    if (en && bus.out_buff_re) bus.out_buff_rdata <= mem[bus.out_buff_raddr];

  // Track the deepest FIFO occupancy ever seen.
  always @(negedge clk)
    if (int'(dut.u_fifo.count) > max_cnt) max_cnt = int'(dut.u_fifo.count);

  typedef struct {
    logic        rst, en, start;
    logic [10:0] cnt;
    logic        tready;
    logic        re;
    logic [9:0]  raddr;
    logic        tvalid;
    logic [15:0] tdata;
    logic        chk_td;
    logic        tlast, busy, done;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic e, logic s, logic [10:0] c, logic tr,
                              logic re, logic [9:0] ra, logic tv, logic [15:0] td,
                              logic ctd, logic tl, logic b, logic d);
    vec_t v;
    v.rst = r; v.en = e; v.start = s; v.cnt = c; v.tready = tr;
    v.re = re; v.raddr = ra; v.tvalid = tv; v.tdata = td; v.chk_td = ctd;
    v.tlast = tl; v.busy = b; v.done = d;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Launch an n-sample block and watch it to completion.
  // mode 0: tready=1; mode 1: tready high one cycle in three; mode 2: tready=1, en low cycles 5..9.
  task automatic stream_check(input int n, input int mode);
    int reads = 0, beats = 0, rd_err = 0, dat_err = 0, last_err = 0;
    int stab_err = 0, frz_err = 0, seq_err = 0, done_cyc = -1;
    logic ptv = 1'b0, phs = 1'b0, pen = 1'b1, ptl = 1'b0, pb = 1'b0, hs;
    logic [15:0] ptd = '0;
    logic [9:0]  pra = '0;
    for (int c = 0; c < n + 40; c++) begin
      start        = (c == 0);
      sample_count = 11'(n);
      en           = !(mode == 2 && c >= 5 && c < 10);
      bus.m_axis_tready = (mode == 1) ? (c % 3 == 0) : 1'b1;
      @(negedge clk);
      if (bus.out_buff_re) begin
        if (!en || bus.out_buff_raddr !== 10'(reads)) rd_err++;
        reads++;
      end
      if (ptv && !phs && (!bus.m_axis_tvalid || bus.m_axis_tdata !== ptd)) stab_err++;
      if (!en && !pen && (bus.m_axis_tvalid !== ptv || bus.m_axis_tdata !== ptd ||
          bus.m_axis_tlast !== ptl || busy !== pb || bus.out_buff_raddr !== pra)) frz_err++;
      hs = en && bus.m_axis_tvalid && bus.m_axis_tready;
      if (hs) begin
        if (bus.m_axis_tdata !== 16'h0011 + 16'(beats)) dat_err++;
        if (bus.m_axis_tlast !== 1'(beats == n - 1)) last_err++;
        if (mode == 0 && c != 3 + beats) seq_err++;
        beats++;
      end
      if (done && done_cyc < 0) done_cyc = c;
      ptv = bus.m_axis_tvalid; ptd = bus.m_axis_tdata; ptl = bus.m_axis_tlast;
      pb = busy; pra = bus.out_buff_raddr; phs = hs; pen = en;
      @(posedge clk); #1;
      if (done_cyc >= 0 && c >= done_cyc + 2) break;
    end
    start = 1'b0; en = 1'b1; bus.m_axis_tready = 1'b1;
    chk($sformatf("m%0d_n%0d_done_seen", mode, n), 32'(done_cyc >= 0), 1);
    chk($sformatf("m%0d_n%0d_reads", mode, n), reads, n);
    chk($sformatf("m%0d_n%0d_beats", mode, n), beats, n);
    chk($sformatf("m%0d_n%0d_raddr_errs", mode, n), rd_err, 0);
    chk($sformatf("m%0d_n%0d_data_errs", mode, n), dat_err, 0);
    chk($sformatf("m%0d_n%0d_tlast_errs", mode, n), last_err, 0);
    chk($sformatf("m%0d_n%0d_stall_errs", mode, n), stab_err, 0);
    if (mode == 0) begin
      chk($sformatf("m0_n%0d_bubble_errs", n), seq_err, 0);
      chk($sformatf("m0_n%0d_done_cycle", n), done_cyc, n + 2);
    end
    if (mode == 2) begin
      chk($sformatf("m2_n%0d_freeze_errs", n), frz_err, 0);
      chk($sformatf("m2_n%0d_done_cycle", n), done_cyc, n + 7);
    end
    @(negedge clk);
    chk($sformatf("m%0d_n%0d_idle_after", mode, n),
        {29'd0, busy, bus.m_axis_tvalid, bus.out_buff_re}, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    int   hs_cnt;
    logic bad;
    for (int i = 0; i < 1024; i++) mem[i] = 16'h0011 + 16'(i);

    // reset, empty block, then 4 samples (start at c3 must be ignored)
    tbl.push_back(mk(1,1,0,0,1, 0,0,0,16'h0000,1,0,0,0));
    tbl.push_back(mk(0,1,1,0,1, 0,0,0,16'h0000,0,0,0,0));
    tbl.push_back(mk(0,1,0,0,1, 0,0,0,16'h0000,0,0,0,1));
    tbl.push_back(mk(0,1,0,0,1, 0,0,0,16'h0000,0,0,0,0));
    tbl.push_back(mk(0,1,1,4,1, 0,0,0,16'h0000,0,0,0,0));
    tbl.push_back(mk(0,1,0,4,1, 1,0,0,16'h0000,0,0,1,0));
    tbl.push_back(mk(0,1,0,4,1, 1,1,0,16'h0000,0,0,1,0));
    tbl.push_back(mk(0,1,1,7,1, 1,2,1,16'h0011,0,0,1,0));
    tbl.push_back(mk(0,1,0,4,1, 1,3,1,16'h0012,0,0,1,0));
    tbl.push_back(mk(0,1,0,4,1, 0,4,1,16'h0013,0,0,1,0));
    tbl.push_back(mk(0,1,0,4,1, 0,4,1,16'h0014,0,1,1,1));
    tbl.push_back(mk(0,1,0,4,1, 0,4,0,16'h0000,0,0,0,0));

    rst = 1'b1; en = 1'b1; start = 1'b0; sample_count = '0; bus.m_axis_tready = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    foreach (tbl[i]) begin
      rst = tbl[i].rst; en = tbl[i].en; start = tbl[i].start;
      sample_count = tbl[i].cnt; bus.m_axis_tready = tbl[i].tready;
      @(negedge clk);
      n_vec++;
      bad = (bus.out_buff_re !== tbl[i].re) || (bus.out_buff_raddr !== tbl[i].raddr) ||
            (bus.m_axis_tvalid !== tbl[i].tvalid) || (bus.m_axis_tlast !== tbl[i].tlast) ||
            (busy !== tbl[i].busy) || (done !== tbl[i].done) ||
            ((tbl[i].tvalid || tbl[i].chk_td) && bus.m_axis_tdata !== tbl[i].tdata);
      if (bad) begin
        n_err++;
        $display("FAIL vec%0d re/raddr/tvalid/tdata/tlast/busy/done: got %b/%0d/%b/%h/%b/%b/%b exp %b/%0d/%b/%h/%b/%b/%b",
                 i, bus.out_buff_re, bus.out_buff_raddr, bus.m_axis_tvalid, bus.m_axis_tdata,
                 bus.m_axis_tlast, busy, done, tbl[i].re, tbl[i].raddr, tbl[i].tvalid,
                 tbl[i].tdata, tbl[i].tlast, tbl[i].busy, tbl[i].done);
      end
      @(posedge clk); #1;
    end
    start = 1'b0;

    stream_check(4, 1);
    stream_check(1024, 0);

    // mid-stream reset after two beats, then a fresh 3-sample block
    hs_cnt = 0;
    for (int c = 0; c < 5; c++) begin
      start = (c == 0); sample_count = 11'd8;
      @(negedge clk);
      if (bus.m_axis_tvalid && bus.m_axis_tready) hs_cnt++;
      @(posedge clk); #1;
    end
    start = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("beats_before_rst", hs_cnt, 2);
    chk("after_rst_tvalid", 32'(bus.m_axis_tvalid), 0);
    chk("after_rst_busy", 32'(busy), 0);
    chk("after_rst_raddr", 32'(bus.out_buff_raddr), 0);
    @(posedge clk); #1;
    stream_check(3, 0);

    stream_check(8, 2);
    chk("fifo_max_le2", 32'(max_cnt <= 2), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
